// File: rtl/pp_mem_pkg.sv
// Shared MEM-stage definitions: default widths, buffer depth and the
// store-buffer entry record used by the store buffer and its bench.
package pp_mem_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_DEPTH  = 4;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry storage, head/tail/count bookkeeping and a
// flat export of every entry so the top level can do forwarding compares.
module store_buffer_fifo
    import pp_mem_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_addr,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [ADDR_W-1:0]        o_head_addr,
    output logic [DATA_W-1:0]        o_head_data,
    output logic [PW-1:0]            o_head_ptr,
    output logic [CW-1:0]            o_count,
    output logic [DEPTH*ADDR_W-1:0]  o_entry_addr,
    output logic [DEPTH*DATA_W-1:0]  o_entry_data,
    output logic [DEPTH-1:0]         o_entry_valid
);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry payload: written at tail on push; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // When full, push and pop hit the same slot; the push update
            // comes last so the slot stays valid.
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_next(r_head);
            end
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= f_next(r_tail);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_entry_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
        assign o_entry_data[g*DATA_W +: DATA_W] = r_data[g];
    end

    assign o_entry_valid = r_valid;
    assign o_head_addr   = r_addr[r_head];
    assign o_head_data   = r_data[r_head];
    assign o_head_ptr    = r_head;
    assign o_count       = r_count;

endmodule

// File: rtl/store_buffer_pp.sv
// MEM-stage store buffer: queues stores, drains them to the single RAM port
// in program order, and forwards the youngest matching store to loads.
module store_buffer_pp
    import pp_mem_pkg::*;
#(
    parameter  int DEPTH  = SB_DEPTH,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic              flush_req,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_mem_write,
    output logic              ram_mem_read,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [CW-1:0]     sb_count
);

    logic [ADDR_W-1:0]       w_head_addr;
    logic [DATA_W-1:0]       w_head_data;
    logic [PW-1:0]           w_head_ptr;
    logic [CW-1:0]           w_count;
    logic [DEPTH*ADDR_W-1:0] w_entry_addr;
    logic [DEPTH*DATA_W-1:0] w_entry_data;
    logic [DEPTH-1:0]        w_entry_valid;
    logic                    w_nonempty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_drain;
    logic                    w_fwd_hit;
    logic [DATA_W-1:0]       w_fwd_data;

    assign w_nonempty = (w_count != '0);
    assign w_full     = (w_count == CW'(DEPTH));
    // A load beats a simultaneous (illegal) store: the store is dropped.
    assign w_push     = mem_write && !mem_read;
    // Loads own the RAM port; stores only steal a drain slot when full or flushing.
    assign w_drain    = w_nonempty && !mem_read && (!mem_write || w_full || flush_req);

    store_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_addr   (mem_addr),
        .i_push_data   (mem_wdata),
        .i_pop         (w_drain),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_head_ptr    (w_head_ptr),
        .o_count       (w_count),
        .o_entry_addr  (w_entry_addr),
        .o_entry_data  (w_entry_data),
        .o_entry_valid (w_entry_valid)
    );

    // Youngest-match forwarding: walk oldest to youngest so the last hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = PW'((32'(w_head_ptr) + k) % DEPTH);
            if (w_entry_valid[idx] && (w_entry_addr[idx*ADDR_W +: ADDR_W] == mem_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_entry_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign load_data      = !mem_read ? '0 : (w_fwd_hit ? w_fwd_data : ram_read_data);
    assign stall          = flush_req && w_nonempty;
    assign ram_address    = mem_read ? mem_addr : w_head_addr;
    assign ram_write_data = w_head_data;
    assign ram_mem_write  = w_drain;
    assign ram_mem_read   = mem_read;
    assign sb_count       = w_count;

    a_no_load_store_collision : assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_read && mem_write)
    );

endmodule
